// File: rtl/ccm_scheduler_if.sv
// ccm_scheduler_if: start/config, weight-fetch, CCM strobe and output
// handshake bundle between ccm_scheduler (master) and its environment (slave).
interface ccm_scheduler_if #(
    parameter int DIM_W = 9
);
    logic             start;
    logic [DIM_W-1:0] cfg_width;
    logic [DIM_W-1:0] cfg_height;
    logic             wgt_req;
    logic             wgt_ack;
    logic             Weight_en;
    logic             en;
    logic             en_output;
    logic [DIM_W-1:0] col;
    logic [DIM_W-1:0] row;
    logic             data_rd_en;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic             cfg_err;

    modport master (
        input  start, cfg_width, cfg_height, wgt_ack, out_ready,
        output wgt_req, Weight_en, en, en_output, col, row, data_rd_en,
               out_valid, busy, done, cfg_err
    );

    modport slave (
        output start, cfg_width, cfg_height, wgt_ack, out_ready,
        input  wgt_req, Weight_en, en, en_output, col, row, data_rd_en,
               out_valid, busy, done, cfg_err
    );
endinterface

// File: rtl/ccm_scheduler.sv
// ccm_scheduler: frame sequencer for the CCM. Fetches weights, walks the
// padded frame in raster order, tags pixels that complete a 3x3 window and
// tracks those tags through the CCM pipeline to drive out_valid.
// Optional macro CCM_SCHED_PERF_EN adds perf_cycles/perf_stalls counters.
//
// state  | meaning
// IDLE   | waiting for start; config checked here
// LOAD_W | wgt_req high until wgt_ack is seen
// RUN    | one pixel per non-stalled cycle, raster order
// DRAIN  | flushing the tag pipeline, PIPE_LAT advances
module ccm_scheduler #(
    parameter int PIPE_LAT = 3,
    parameter int DIM_W    = 9
) (
    input  logic               clk,
    input  logic               rst,
`ifdef CCM_SCHED_PERF_EN
    output logic [31:0]        perf_cycles,
    output logic [31:0]        perf_stalls,
`endif
    ccm_scheduler_if.master    bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD_W = 2'd1;
    localparam logic [1:0] RUN    = 2'd2;
    localparam logic [1:0] DRAIN  = 2'd3;

    localparam int CNT_W = $clog2(PIPE_LAT + 1);

    logic [1:0]          state;
    logic [DIM_W-1:0]    col_q;
    logic [DIM_W-1:0]    row_q;
    logic [DIM_W-1:0]    width_q;
    logic [DIM_W-1:0]    height_q;
    logic [PIPE_LAT-1:0] tag_sr;
    logic [CNT_W-1:0]    drain_cnt;
    logic                weight_en_q;
    logic                done_q;
    logic                cfg_err_q;

    logic stall;
    logic run_en;
    logic advance;
    logic tag_in;
    logic cfg_ok;
    logic last_col;
    logic last_row;
    logic drain_last;

    // A pending result the sink refuses freezes the whole pipeline.
    assign stall      = tag_sr[PIPE_LAT-1] & ~bus.out_ready;
    assign run_en     = (state == RUN) & ~stall;
    assign advance    = run_en | ((state == DRAIN) & ~stall);
    assign tag_in     = run_en & (col_q >= DIM_W'(2)) & (row_q >= DIM_W'(2));
    assign cfg_ok     = (bus.cfg_width >= DIM_W'(3)) & (bus.cfg_height >= DIM_W'(3));
    assign last_col   = (col_q == width_q - DIM_W'(1));
    assign last_row   = (row_q == height_q - DIM_W'(1));
    assign drain_last = (drain_cnt == CNT_W'(1));

    // Sequencer state, frame size capture and raster position counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            width_q   <= '0;
            height_q  <= '0;
            col_q     <= '0;
            row_q     <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && cfg_ok) begin
                        state    <= LOAD_W;
                        width_q  <= bus.cfg_width;
                        height_q <= bus.cfg_height;
                        col_q    <= '0;
                        row_q    <= '0;
                    end
                end
                LOAD_W: begin
                    if (bus.wgt_ack) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (run_en) begin
                        if (last_col) begin
                            col_q <= '0;
                            if (last_row) begin
                                row_q     <= '0;
                                state     <= DRAIN;
                                drain_cnt <= CNT_W'(PIPE_LAT);
                            end else begin
                                row_q <= row_q + DIM_W'(1);
                            end
                        end else begin
                            col_q <= col_q + DIM_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (advance) begin
                        drain_cnt <= drain_cnt - CNT_W'(1);
                        if (drain_last) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Single-cycle strobes: weight latch, config error and frame done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            weight_en_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            weight_en_q <= (state == LOAD_W) & bus.wgt_ack;
            cfg_err_q   <= (state == IDLE) & bus.start & ~cfg_ok;
            done_q      <= (state == DRAIN) & advance & drain_last;
        end
    end

    // Window tags ride alongside the CCM pipeline; the oldest one is out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_sr <= '0;
        end else if (advance) begin
            tag_sr <= (tag_sr << 1) | PIPE_LAT'(tag_in);
        end
    end

`ifdef CCM_SCHED_PERF_EN
    // Busy and stall cycle counters, cleared when a frame is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if (state == IDLE) begin
            if (bus.start && cfg_ok) begin
                perf_cycles <= '0;
                perf_stalls <= '0;
            end
        end else begin
            perf_cycles <= perf_cycles + 32'd1;
            if (stall) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
        end
    end
`endif

    assign bus.wgt_req    = (state == LOAD_W);
    assign bus.Weight_en  = weight_en_q;
    assign bus.en         = run_en;
    assign bus.en_output  = run_en;
    assign bus.data_rd_en = run_en;
    assign bus.col        = col_q;
    assign bus.row        = row_q;
    assign bus.out_valid  = tag_sr[PIPE_LAT-1];
    assign bus.busy       = (state != IDLE);
    assign bus.done       = done_q;
    assign bus.cfg_err    = cfg_err_q;
endmodule

// File: doc/ccm_scheduler.md
CCM_SCHEDULER -- requirements
Module: ccm_scheduler

Interface
REQ-001 SHALL have parameter PIPE_LAT, default 3: cycles from an en-high cycle to the matching partial_sum at the CCM output.
REQ-002 SHALL have parameter DIM_W, default 9: width of the col, row and cfg_* fields.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: one-cycle request to process one frame.
REQ-006 SHALL have ports cfg_width and cfg_height, input, DIM_W each: padded frame size, sampled on the cycle start is accepted.
REQ-007 SHALL have ports wgt_req (output, 1) and wgt_ack (input, 1): weight-fetch handshake with the weight SRAM.
REQ-008 SHALL have port Weight_en, output, 1: weight-latch strobe to the CCM.
REQ-009 SHALL have ports en and en_output, output, 1 each: compute enable and row-stack enable to the CCM.
REQ-010 SHALL have ports col and row, output, DIM_W each: current pixel position.
REQ-011 SHALL have port data_rd_en, output, 1: pixel-fetch strobe, equal to en.
REQ-012 SHALL have ports out_valid (output, 1) and out_ready (input, 1): partial_sum handshake with the sink.
REQ-013 SHALL have ports busy, done and cfg_err, output, 1 each.

Function
REQ-014 SHALL implement the FSM IDLE -> LOAD_W -> RUN -> DRAIN -> IDLE.
REQ-015 IDLE: start with cfg_width>=3 and cfg_height>=3 -> LOAD_W next cycle and busy=1; otherwise cfg_err pulses for 1 cycle and the FSM stays in IDLE.
REQ-016 start while busy SHALL be ignored and SHALL NOT cause cfg_err.
REQ-017 LOAD_W: wgt_req held high until wgt_ack is sampled high; on the cycle after the ack, Weight_en pulses for 1 cycle and the FSM enters RUN with col=row=0.
REQ-018 RUN: en=en_output=data_rd_en=1 on every non-stalled cycle.
REQ-019 RUN counting: col increments per en cycle; at col=cfg_width-1, col wraps to 0 and row increments.
REQ-020 RUN exit: the en cycle at col=cfg_width-1 and row=cfg_height-1 is the last one; the FSM then enters DRAIN.
REQ-021 Window tag: a tag bit is 1 when col>=2 and row>=2 during an en cycle.
REQ-022 Tag pipeline: the tag enters a PIPE_LAT-deep shift register that advances only on en cycles or DRAIN cycles.
REQ-023 out_valid SHALL equal the last stage of the tag shift register.
REQ-024 Stall: when out_valid=1 and out_ready=0, en, en_output and data_rd_en are 0, and col, row and the shift register hold their values.
REQ-025 DRAIN: the shift register advances PIPE_LAT times, honouring stalls; then done pulses for 1 cycle, busy=0 and the FSM returns to IDLE.
REQ-026 Each frame SHALL produce exactly (cfg_width-2)*(cfg_height-2) out_valid handshakes.
REQ-027 cfg_width=cfg_height=511 SHALL complete without counter overflow.

Reset
REQ-028 Asserting rst SHALL force IDLE with every output 0, col=row=0 and the shift register cleared.
REQ-029 Reset mid-frame SHALL abort the frame; no done pulse is produced and the frame is not resumed.
REQ-030 After rst is released, the first start SHALL be accepted normally.

Configuration
REQ-031 With CCM_SCHED_PERF_EN defined, the block SHALL add outputs perf_cycles and perf_stalls (32-bit each).
REQ-032 With CCM_SCHED_PERF_EN defined, perf_cycles counts busy cycles and perf_stalls counts stall cycles; both clear on accepted start and hold after done.
REQ-033 Without CCM_SCHED_PERF_EN, the ports and counters SHALL be absent and the remaining behaviour SHALL be identical.

Verification
REQ-034 5x5 frame, PIPE_LAT=3, out_ready=1, wgt_ack 2 cycles after wgt_req -> 1 Weight_en pulse, 25 en cycles, 9 out_valid, done on cycle 25+3 after the first en.
REQ-035 5x5 frame with out_ready=0 for 4 cycles at the first out_valid -> col/row frozen for 4 cycles, still 9 handshakes, perf_stalls=4.
REQ-036 start with cfg_width=2 -> 1-cycle cfg_err, busy stays 0, no wgt_req.
REQ-037 rst asserted at row=2 col=3 of a 6x6 frame -> all outputs 0 next edge, no done; a new 3x3 start yields exactly 1 out_valid.
REQ-038 start pulsed during RUN of an 8x4 frame -> ignored; still 12 handshakes and a single done.
REQ-039 511x3 frame -> col wraps at 510, 509 out_valid, done issued.
